// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the message sources, the shared UART byte transmitter and the arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment's view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_done;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, grant, tx_data, tx_start, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, grant, tx_data, tx_start, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART byte transmitter among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to abort a granted packet that stalls for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 1..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    START,
    WAIT_DONE
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic               last_q;
  logic               timeout_err_q;

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               sel_valid;
  logic [IDX_W-1:0]   next_ptr;

  // Two passes give the circular search: first rr_ptr..NUM_REQ-1, then 0..rr_ptr-1.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin : pick_winner
    win_oh    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.req_valid[i] && (i >= int'(rr_ptr))) begin
        win_found  = 1'b1;
        win_oh[i]  = 1'b1;
        win_idx    = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.req_valid[i]) begin
        win_found  = 1'b1;
        win_oh[i]  = 1'b1;
        win_idx    = IDX_W'(i);
      end
    end
  end

  // The one-hot grant selects the owner's byte without any index arithmetic.
  always_comb begin : owner_mux
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data = bus.req_data[8*i +: 8];
        sel_last = bus.req_last[i];
      end
    end
  end

  assign sel_valid = |(bus.req_valid & grant_q);
  assign next_ptr  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr        <= '0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      last_q        <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      // Held at zero outside WAIT_BYTE, so each entry starts a fresh stall window.
      if (state != WAIT_BYTE) tmo_cnt <= '0;
`endif
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant_q <= win_oh;
            owner_q <= win_idx;
            state   <= WAIT_BYTE;
          end
        end
        WAIT_BYTE: begin
          if (sel_valid) begin
            tx_data_q  <= sel_data;
            last_q     <= sel_last;
            tx_start_q <= 1'b1;
            state      <= START;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            grant_q       <= '0;
            rr_ptr        <= next_ptr;
            timeout_err_q <= 1'b1;
            state         <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            if (last_q) begin
              grant_q <= '0;
              rr_ptr  <= next_ptr;
              state   <= IDLE;
            end else begin
              state <= WAIT_BYTE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == WAIT_BYTE) ? grant_q : '0;
  assign bus.grant       = grant_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
// The bench plays both the requesters and the UART transmitter.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for the START cycle and checks owner and byte.
  task automatic wait_start(input string tag, input logic [3:0] exp_grant, input logic [7:0] exp_data);
    int n = 0;
    while (bus.tx_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(bus.tx_start), 32'd1);
    check({tag, "_grant"}, 32'(bus.grant), 32'(exp_grant));
    check({tag, "_data"}, 32'(bus.tx_data), 32'(exp_data));
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  // Transmitter side: a few busy cycles with tx_data held, then a one-cycle tx_done.
  task automatic finish_byte(input string tag, input logic [7:0] exp_data);
    tick();
    check({tag, "_pulse_end"}, 32'(bus.tx_start), 32'd0);
    tick();
    tick();
    check({tag, "_hold"}, 32'(bus.tx_data), 32'(exp_data));
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  initial begin
    logic seen_tmo;
    logic seen_start;
    logic seen_ready;
    logic grant_moved;
    bus.req_data = '0;

    // Reset state
    do_reset();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);

    // 1) Single-byte packet from requester 0
    bus.req_valid = 4'b0001;
    bus.req_data[7:0] = 8'h41;
    bus.req_last = 4'b0001;
    tick();
    check("t1_grant", 32'(bus.grant), 32'b0001);
    check("t1_ready", 32'(bus.req_ready), 32'b0001);
    check("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.req_valid = 4'b0000;
    check("t1_start", 32'(bus.tx_start), 32'd1);
    check("t1_data", 32'(bus.tx_data), 32'h41);
    check("t1_ready_drop", 32'(bus.req_ready), 32'd0);
    finish_byte("t1", 8'h41);
    check("t1_release_grant", 32'(bus.grant), 32'd0);
    check("t1_release_busy", 32'(bus.busy), 32'd0);

    // 2) All four requesters hold single-byte packets: strict rotation
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    wait_start("t2_r0", 4'b0001, 8'h10);
    finish_byte("t2_r0", 8'h10);
    wait_start("t2_r1", 4'b0010, 8'h11);
    finish_byte("t2_r1", 8'h11);
    wait_start("t2_r2", 4'b0100, 8'h12);
    finish_byte("t2_r2", 8'h12);
    wait_start("t2_r3", 4'b1000, 8'h13);
    finish_byte("t2_r3", 8'h13);
    wait_start("t2_wrap", 4'b0001, 8'h10);
    bus.req_valid = 4'b0000;
    finish_byte("t2_wrap", 8'h10);
    check("t2_idle", 32'(bus.busy), 32'd0);

    // 3) Requester 2 sends "ABC" while requester 0 waits
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0000;
    bus.req_data  = {8'h00, 8'h41, 8'h00, 8'h30};
    tick();
    check("t3_grant", 32'(bus.grant), 32'b0100);
    bus.req_valid = 4'b0101;
    bus.req_last  = 4'b0001;
    wait_start("t3_A", 4'b0100, 8'h41);
    bus.req_data[23:16] = 8'h42;
    finish_byte("t3_A", 8'h41);
    wait_start("t3_B", 4'b0100, 8'h42);
    bus.req_data[23:16] = 8'h43;
    bus.req_last = 4'b0101;
    finish_byte("t3_B", 8'h42);
    wait_start("t3_C", 4'b0100, 8'h43);
    bus.req_valid = 4'b0001;
    finish_byte("t3_C", 8'h43);
    check("t3_release", 32'(bus.grant), 32'd0);
    wait_start("t3_next", 4'b0001, 8'h30);
    bus.req_valid = 4'b0000;
    finish_byte("t3_next", 8'h30);

    // 4) Reset in WAIT_DONE of byte 2 of 3, coinciding with tx_done
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0000;
    bus.req_data  = {8'h00, 8'h00, 8'h61, 8'h00};
    wait_start("t4_a", 4'b0010, 8'h61);
    bus.req_data[15:8] = 8'h62;
    finish_byte("t4_a", 8'h61);
    wait_start("t4_b", 4'b0010, 8'h62);
    bus.req_data[15:8] = 8'h63;
    bus.req_last = 4'b0010;
    tick();
    check("t4_wait_done_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.tx_done = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    bus.tx_done = 1'b0;
    check("t4_grant", 32'(bus.grant), 32'd0);
    check("t4_start", 32'(bus.tx_start), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_data", 32'(bus.tx_data), 32'd0);
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    seen_start = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen_start |= bus.tx_start;
      seen_ready |= |bus.req_ready;
      tick();
    end
    check("t4_late_done_start", 32'(seen_start), 32'd0);
    check("t4_late_done_ready", 32'(seen_ready), 32'd0);
    check("t4_late_done_busy", 32'(bus.busy), 32'd0);

    // 5/6) Requester 1 stalls mid-packet
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0000;
    bus.req_data  = {8'h33, 8'h00, 8'h78, 8'h00};
    wait_start("t56_x", 4'b0010, 8'h78);
    bus.req_valid = 4'b0000;
    finish_byte("t56_x", 8'h78);
    bus.req_valid = 4'b1001;
    bus.req_last  = 4'b1001;
    seen_tmo = 1'b0;
    grant_moved = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      seen_tmo |= bus.timeout_err;
      grant_moved |= (bus.grant !== 4'b0010);
      tick();
    end
    seen_tmo |= bus.timeout_err;
    grant_moved |= (bus.grant !== 4'b0010);
    check("t5_no_early_timeout", 32'(seen_tmo), 32'd0);
    check("t5_grant_held", 32'(grant_moved), 32'd0);
    tick();
    check("t5_timeout_pulse", 32'(bus.timeout_err), 32'd1);
    check("t5_timeout_grant", 32'(bus.grant), 32'd0);
    check("t5_timeout_busy", 32'(bus.busy), 32'd0);
    tick();
    check("t5_pulse_width", 32'(bus.timeout_err), 32'd0);
    check("t5_next_winner", 32'(bus.grant), 32'b1000);
    wait_start("t5_next", 4'b1000, 8'h33);
    bus.req_valid = 4'b0000;
    finish_byte("t5_next", 8'h33);
`else
    seen_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_tmo |= bus.timeout_err;
      seen_start |= bus.tx_start;
      grant_moved |= (bus.grant !== 4'b0010);
      tick();
    end
    check("t6_no_timeout", 32'(seen_tmo), 32'd0);
    check("t6_grant_locked", 32'(grant_moved), 32'd0);
    check("t6_no_start", 32'(seen_start), 32'd0);
    check("t6_ready", 32'(bus.req_ready), 32'b0010);
    check("t6_busy", 32'(bus.busy), 32'd1);
    bus.req_data[15:8] = 8'h79;
    bus.req_valid = 4'b1011;
    bus.req_last  = 4'b1011;
    wait_start("t6_y", 4'b0010, 8'h79);
    bus.req_valid = 4'b1000;
    finish_byte("t6_y", 8'h79);
    wait_start("t6_next", 4'b1000, 8'h33);
    bus.req_valid = 4'b0000;
    finish_byte("t6_next", 8'h33);
`endif
    check("end_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
